// File: rtl/enemigo_pkg.sv
// Shared types and constants for the enemy car motion controller.
package enemigo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RUN,
        CRASH
    } state_e;

    localparam logic [9:0] LANE_X [4] = '{10'd120, 10'd220, 10'd320, 10'd420};

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps b7, b5, b4, b3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int unsigned BLINK_PERIOD = 8;
    localparam int unsigned BLINK_BIT    = $clog2(BLINK_PERIOD);

endpackage

// File: rtl/enemigo_lfsr.sv
// 8-bit Fibonacci LFSR (shift left), seed loaded on reset; exposes the
// low six bits used for lane and spawn-delay selection.
module enemigo_lfsr
    import enemigo_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       advance,
    output logic [5:0] sel
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign sel = lfsr_q[5:0];

endmodule

// File: rtl/enemigo_ctrl.sv
// Enemy car motion controller: spawn, scroll, despawn and crash sequencing.
// Define ENEMIGO_BLINK_EN to make the wreck blink during CRASH.
module enemigo_ctrl
    import enemigo_pkg::*;
#(
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned CRASH_FRAMES = 60,
    parameter int unsigned SPAWN_BASE   = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [2:0] speed,
    input  logic       collision,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       enable,
    output logic       crashed,
    output logic       score_pulse
);

    localparam logic [10:0] SCREEN_LIM = 11'(SCREEN_H);
    localparam logic [15:0] CRASH_LIM  = 16'(CRASH_FRAMES);
    localparam logic [7:0]  DELAY_BASE = 8'(SPAWN_BASE);

    state_e      state_q, state_d;
    logic [9:0]  posx_q, posx_d;
    logic [9:0]  posy_q, posy_d;
    logic        enable_q, enable_d;
    logic        crashed_q, crashed_d;
    logic        score_q, score_d;
    logic [7:0]  delay_q, delay_d;
    logic [15:0] crash_cnt_q, crash_cnt_d;

    logic [5:0]  sel;
    logic        lfsr_adv;
    logic        respawn;
    logic [10:0] posy_sum;

    enemigo_lfsr u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (lfsr_adv),
        .sel     (sel)
    );

    always_comb begin
        state_d     = state_q;
        posx_d      = posx_q;
        posy_d      = posy_q;
        enable_d    = enable_q;
        crashed_d   = crashed_q;
        score_d     = 1'b0;
        delay_d     = delay_q;
        crash_cnt_d = crash_cnt_q;
        respawn     = 1'b0;
        lfsr_adv    = frame_tick && (state_q != IDLE);
        posy_sum    = {1'b0, posy_q} + {8'b0, speed} + 11'd1;

        case (state_q)
            IDLE: begin
                enable_d = 1'b0;
                if (start) begin
                    respawn = 1'b1;
                end
            end
            WAIT: begin
                if (frame_tick) begin
                    delay_d = delay_q - 8'd1;
                    if (delay_q <= 8'd1) begin
                        state_d  = RUN;
                        enable_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Collision takes priority over a coincident move tick
                if (collision) begin
                    state_d     = CRASH;
                    crashed_d   = 1'b1;
                    crash_cnt_d = '0;
                end else if (frame_tick) begin
                    if (posy_sum >= SCREEN_LIM) begin
                        score_d = 1'b1;
                        respawn = 1'b1;
                    end else begin
                        posy_d = posy_sum[9:0];
                    end
                end
            end
            CRASH: begin
                if (frame_tick) begin
                    crash_cnt_d = crash_cnt_q + 16'd1;
                    if (crash_cnt_d == CRASH_LIM) begin
                        respawn = 1'b1;
                    end
`ifdef ENEMIGO_BLINK_EN
                    else begin
                        enable_d = ~crash_cnt_d[BLINK_BIT];
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lane and delay come from the LFSR value before this edge's advance
        if (respawn) begin
            state_d   = WAIT;
            posx_d    = LANE_X[sel[5:4]];
            posy_d    = '0;
            delay_d   = DELAY_BASE + {4'b0, sel[3:0]};
            enable_d  = 1'b0;
            crashed_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            posx_q      <= '0;
            posy_q      <= '0;
            enable_q    <= 1'b0;
            crashed_q   <= 1'b0;
            score_q     <= 1'b0;
            delay_q     <= '0;
            crash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            posx_q      <= posx_d;
            posy_q      <= posy_d;
            enable_q    <= enable_d;
            crashed_q   <= crashed_d;
            score_q     <= score_d;
            delay_q     <= delay_d;
            crash_cnt_q <= crash_cnt_d;
        end
    end

    assign posx        = posx_q;
    assign posy        = posy_q;
    assign enable      = enable_q;
    assign crashed     = crashed_q;
    assign score_pulse = score_q;

endmodule
